// File: rtl/mem_wb_register.sv
// Memory-access stage and MEM/WB pipeline register.
// Drives the synchronous data memory from the EX/MEM bundle, registers the
// write-back bundle, and returns extended load data, holding the loaded word
// stable while the pipeline is stalled.
module mem_wb_register #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  input  logic [31:0] ex_instr,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  output logic [31:0] dmem_addr,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic [33:0] MEMWB,
  output logic [31:0] MEM_DATA,
  output logic [31:0] ALU_DATA,
  output logic        misalign
);

  logic [2:0]  w_f3;
  logic [1:0]  w_addr_lo;
  logic        w_load_legal;
  logic        w_store_legal;
  logic        w_misaligned;
  logic        w_bad;
  logic        w_issue_ok;
  logic [31:0] w_raw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  logic [33:0] r_memwb;
  logic [31:0] r_alu;
  logic        r_misalign;
  logic        r_fresh;
  logic [31:0] r_hold;

  assign w_f3      = ex_instr[14:12];
  assign w_addr_lo = ex_alu_result[1:0];

  assign w_load_legal  = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                         (w_f3 == 3'b100) || (w_f3 == 3'b101);
  assign w_store_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
  assign w_misaligned  = ((w_f3[1:0] == 2'b01) && w_addr_lo[0]) ||
                         ((w_f3[1:0] == 2'b10) && (w_addr_lo != 2'b00));

  // A bad access is only meaningful for loads/stores; ALU ops are never bad.
  assign w_bad = (ex_mem_read  && (!w_load_legal  || w_misaligned)) ||
                 (ex_mem_write && (!w_store_legal || w_misaligned));

  // Stalled or flushed cycles must not touch memory, so a held store is not repeated.
  assign w_issue_ok = !w_bad && !stall && !flush;
  assign dmem_re    = ex_mem_read  && w_issue_ok;
  assign dmem_we    = ex_mem_write && w_issue_ok;
  assign dmem_addr  = {ex_alu_result[31:2], 2'b00};

  // Store lane selection: replicate the datum across lanes, enable only the target bytes.
  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = ex_store_data;
    case (w_f3[1:0])
      2'b00: begin
        dmem_wdata = {4{ex_store_data[7:0]}};
        dmem_be    = 4'b0001 << w_addr_lo;
      end
      2'b01: begin
        dmem_wdata = {2{ex_store_data[15:0]}};
        dmem_be    = w_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dmem_wdata = ex_store_data;
        dmem_be    = 4'b1111;
      end
    endcase
    if (!dmem_we) begin
      dmem_be = 4'b0000;
    end
  end

  // MEM/WB register: reset and flush insert a bubble, stall holds, otherwise capture EX/MEM.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_memwb    <= {2'b00, NOP_INSTR};
      r_alu      <= 32'd0;
      r_misalign <= 1'b0;
    end else if (!stall) begin
      r_memwb    <= {ex_mem_to_reg, ex_reg_write && !w_bad, ex_instr};
      r_alu      <= ex_alu_result;
      r_misalign <= w_bad && (ex_mem_read || ex_mem_write);
    end
  end

  // Load-data hold: memory output is only valid one cycle, so capture it on the first stalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold  <= 32'd0;
      r_fresh <= 1'b0;
    end else if (flush) begin
      r_fresh <= 1'b0;
    end else if (stall) begin
      if (r_fresh) begin
        r_hold  <= dmem_rdata;
        r_fresh <= 1'b0;
      end
    end else begin
      r_fresh <= ex_mem_read && !w_bad;
    end
  end

  assign w_raw  = r_fresh ? dmem_rdata : r_hold;
  assign w_half = r_alu[1] ? w_raw[31:16] : w_raw[15:0];

  // Byte lane pick for LB/LBU.
  always_comb begin
    w_byte = w_raw[7:0];
    case (r_alu[1:0])
      2'b00:   w_byte = w_raw[7:0];
      2'b01:   w_byte = w_raw[15:8];
      2'b10:   w_byte = w_raw[23:16];
      default: w_byte = w_raw[31:24];
    endcase
  end

  // Extend the selected lane according to the write-back instruction's funct3.
  always_comb begin
    MEM_DATA = 32'd0;
    case (r_memwb[14:12])
      3'b000:  MEM_DATA = {{24{w_byte[7]}}, w_byte};
      3'b001:  MEM_DATA = {{16{w_half[15]}}, w_half};
      3'b010:  MEM_DATA = w_raw;
      3'b100:  MEM_DATA = {24'd0, w_byte};
      3'b101:  MEM_DATA = {16'd0, w_half};
      default: MEM_DATA = 32'd0;
    endcase
  end

  assign MEMWB    = r_memwb;
  assign ALU_DATA = r_alu;
  assign misalign = r_misalign;

endmodule

// File: doc/mem_wb_register.md
# mem_wb_register

Memory-access stage and MEM/WB pipeline register of the 5-stage RISC-V core. Takes the EX/MEM bundle, drives the synchronous data memory (byte enables, store-data lane shifting), and registers the 34-bit MEMWB bundle plus ALU result. It returns sign- or zero-extended load data as `MEM_DATA` for the write-back stage. It supports pipeline stall and flush, and holds load data stable across stalls.

## Interface
Parameters:
- `NOP_INSTR`, 32'h00000013, instruction word inserted on reset/flush (ADDI x0,x0,0)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  1  hold MEMWB contents this cycle
- `flush`  in  1  load a bubble into MEMWB this cycle
- `ex_mem_read`  in  1  EX/MEM instruction is a load
- `ex_mem_write`  in  1  EX/MEM instruction is a store
- `ex_mem_to_reg`  in  1  write-back selects memory data
- `ex_reg_write`  in  1  instruction writes rd
- `ex_instr`  in  32  instruction word; funct3 = [14:12], rd = [11:7]
- `ex_alu_result`  in  32  ALU result / effective address
- `ex_store_data`  in  32  rs2 value for stores
- `dmem_addr`  out  32  `{ex_alu_result[31:2],2'b00}`
- `dmem_re`  out  1  read enable
- `dmem_we`  out  1  write enable
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-shifted store data
- `dmem_rdata`  in  32  read word, valid the cycle after `dmem_re`
- `MEMWB`  out  34  {MemToReg[33], RegWrite[32], instr[31:0]}
- `MEM_DATA`  out  32  extended load data
- `ALU_DATA`  out  32  registered ALU result
- `misalign`  out  1  registered: MEMWB instruction had a misaligned/illegal access

## Operation
- Alignment check (combinational on EX inputs, loads/stores only): halfword (funct3[1:0]=01) needs addr[0]=0; word (10) needs addr[1:0]=00. Load funct3 ∉ {000,001,010,100,101} and store funct3 ∉ {000,001,010} are illegal. Misaligned or illegal means `bad`.
- `dmem_re = ex_mem_read & ~bad & ~stall & ~flush`. `dmem_we = ex_mem_write & ~bad & ~stall & ~flush`. Stores are never repeated during a stall.
- Stores: SB `be = 1<<addr[1:0]`, `wdata = {4{rs2[7:0]}}`. SH `be = addr[1] ? 1100 : 0011`, `wdata = {2{rs2[15:0]}}`. SW `be = 1111`, `wdata = rs2`. `be = 0000` when not writing.
- Register update, priority: `rst` > `flush` > `stall` > load.
  - rst/flush: `MEMWB = {2'b00, NOP_INSTR}`, `ALU_DATA = 0`, `misalign = 0`, `fresh = 0`.
  - stall: all registers hold.
  - load: `MEMWB = {ex_mem_to_reg, ex_reg_write & ~bad, ex_instr}`, `ALU_DATA = ex_alu_result`, `misalign = bad & (ex_mem_read|ex_mem_write)`, `fresh = ex_mem_read & ~bad`.
- Load-data hold: internal `hold[31:0]` and `fresh`. When `fresh=1 & stall=1`, capture `hold = dmem_rdata` and clear `fresh`. Raw word = `fresh ? dmem_rdata : hold`.
- `MEM_DATA` (combinational) uses MEMWB funct3 and `ALU_DATA[1:0]`: LB/LBU selects byte `addr[1:0]`, sign/zero-extended. LH/LHU selects half `addr[1]`, extended. LW passes the word through. Other funct3 gives 0.

## Timing
- Reset values: `MEMWB = 34'h0_00000013`, `ALU_DATA = 0`, `misalign = 0`, `MEM_DATA = 0`, `hold = 0`, `fresh = 0`.
- DMEM control outputs are combinational from EX inputs, in the same cycle.
- Latency: EX/MEM inputs at edge N appear on `MEMWB`/`ALU_DATA` after edge N. `MEM_DATA` is valid in cycle N+1 from `dmem_rdata`, and stays valid for any number of stall cycles thereafter.
- `stall` and `flush` together: flush wins, and no memory access is issued.
- `rst` mid-stall discards `hold`. The access in the reset cycle is suppressed only through `stall`/`flush`; the core asserts `flush` during `rst`.

## Test plan
- SW x=0xDEADBEEF at 0x100, then LW 0x100 → `dmem_be=1111`, `wdata=DEADBEEF`; next cycle `MEM_DATA=DEADBEEF`, `MEMWB[33:32]=11`.
- Word 0x80FF7F01 at 0x200: LB 0x202 → `FFFFFFFF`; LBU 0x202 → `000000FF`; LH 0x202 → `FFFF80FF`; LHU 0x200 → `00007F01`.
- SH 0x1234 at 0x102 → `be=1100`, `wdata=12341234`. SB 0xAB at 0x103 → `be=1000`.
- LW at 0x102 → `dmem_re=0`; next cycle `misalign=1`, `MEMWB[32]=0`. LH at 0x101 behaves the same.
- LW returns 0xCAFEF00D, then 3 stall cycles while `dmem_rdata` changes to 0 → `MEM_DATA` stays `CAFEF00D`; SW held under stall gives `dmem_we=0` in every stalled cycle.
- `flush` together with `stall`, with a valid load presented → `MEMWB=0_00000013`, `dmem_re=0`. `rst` gives the same outputs.
